// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared types and constants for the decoder scan sequencer.
package decoder_scan_sequencer_pkg;

    localparam int unsigned DWELL_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/decoder_scan_sequencer_if.sv
// Control/status bundle between the scan sequencer and its controller.
interface decoder_scan_sequencer_if;

    logic start;
    logic stop;
    logic cont;
    logic en;
    logic a1;
    logic a0;
    logic busy;
    logic done;

    modport master (
        output start, stop, cont,
        input  en, a1, a0, busy, done
    );

    modport slave (
        input  start, stop, cont,
        output en, a1, a0, busy, done
    );

endinterface

// File: rtl/decoder_scan_sequencer_dwell_timer.sv
// Counts cycles within one address slot; slot_end flags the last cycle of the slot.
module dwell_timer #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick,
    output logic slot_end
);

    localparam int CNT_W = $clog2(DWELL) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign slot_end = tick && (cnt_q == CNT_W'(DWELL - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr || slot_end) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Steps a 2-to-4 decoder address through 00..11, holding each slot DWELL cycles,
// in one-shot or continuous mode. All outputs come straight from flops.
module decoder_scan_sequencer
    import decoder_scan_sequencer_pkg::*;
#(
    parameter int unsigned DWELL = DWELL_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    decoder_scan_sequencer_if.slave   bus
);

    scan_state_e state_q, state_d;
    logic [1:0]  addr_q, addr_d;
    logic        cont_q, cont_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        slot_end;

    dwell_timer #(.DWELL(DWELL)) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      ((state_q != SCAN) || bus.stop),
        .tick     (state_q == SCAN),
        .slot_end (slot_end)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cont_d  = cont_q;
        case (state_q)
            IDLE: begin
                addr_d = 2'b00;
                if (bus.start && !bus.stop) begin
                    state_d = SCAN;
                    cont_d  = bus.cont;
                end
            end
            SCAN: begin
                // stop outranks both slot advance and wrap
                if (bus.stop) begin
                    state_d = IDLE;
                    addr_d  = 2'b00;
                end else if (slot_end) begin
                    addr_d = addr_q + 2'd1;
                    if ((addr_q == 2'b11) && !cont_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                addr_d  = 2'b00;
            end
            default: begin
                state_d = IDLE;
                addr_d  = 2'b00;
            end
        endcase
        en_d   = (state_d == SCAN);
        busy_d = (state_d == SCAN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 2'b00;
            cont_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cont_q  <= cont_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.en   = en_q;
    assign bus.a1   = addr_q[1];
    assign bus.a0   = addr_q[0];
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Drives DWELL=4 and DWELL=1 sequencers with the same stimulus and checks both
// against a time-since-start model of the scan.
module tb_decoder_scan_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    decoder_scan_sequencer_if bus4 ();
    decoder_scan_sequencer_if bus1 ();

    decoder_scan_sequencer #(.DWELL(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    decoder_scan_sequencer #(.DWELL(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: phase 0=idle 1=scan 2=done; tt = cycles elapsed in the current pass.
    int ph [2] = '{0, 0};
    int tt [2] = '{0, 0};
    int lc [2] = '{0, 0};
    int dw [2] = '{4, 1};

    task automatic drive(input bit s, input bit p, input bit c);
        bus4.start = s; bus4.stop = p; bus4.cont = c;
        bus1.start = s; bus1.stop = p; bus1.cont = c;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0; tt[i] = 0; lc[i] = 0;
        end
    endtask

    task automatic model_edge(input bit s, input bit p, input bit c);
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            case (ph[i])
                0: if (s && !p) begin
                    ph[i] = 1; tt[i] = 0; lc[i] = int'(c);
                end
                1: if (p) begin
                    ph[i] = 0;
                end else begin
                    tt[i] = tt[i] + 1;
                    if (tt[i] == 4 * dw[i]) begin
                        if (lc[i] != 0) tt[i] = 0;
                        else ph[i] = 2;
                    end
                end
                default: ph[i] = 0;
            endcase
        end
    endtask

    function automatic logic [4:0] expv(input int i);
        logic [1:0] a;
        a = 2'(tt[i] / dw[i]);
        case (ph[i])
            1:       return {1'b1, a, 1'b1, 1'b0};
            2:       return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic check(input string tag);
        logic [4:0] o4, o1, e4, e1;
        o4 = {bus4.en, bus4.a1, bus4.a0, bus4.busy, bus4.done};
        o1 = {bus1.en, bus1.a1, bus1.a0, bus1.busy, bus1.done};
        e4 = expv(0);
        e1 = expv(1);
        vectors++;
        assert (o4 === e4) else begin
            miscompares++;
            $error("FAIL %s dwell4 {en,a1,a0,busy,done} got %b want %b", tag, o4, e4);
        end
        vectors++;
        assert (o1 === e1) else begin
            miscompares++;
            $error("FAIL %s dwell1 {en,a1,a0,busy,done} got %b want %b", tag, o1, e1);
        end
    endtask

    task automatic step(input bit s, input bit p, input bit c, input string tag);
        drive(s, p, c);
        @(posedge clk);
        model_edge(s, p, c);
        @(negedge clk);
        check(tag);
    endtask

    task automatic idle_steps(input int n, input string tag);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, tag);
    endtask

    // Called just after a falling edge: asserts reset between edges and checks at once.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check(tag);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check("reset_immediate");
        for (int k = 0; k < 4; k++) step(k[0], 1'b0, 1'b0, "reset_hold_start_toggle");
        rst_n = 1'b1;
        idle_steps(3, "post_reset_idle");

        step(1'b1, 1'b0, 1'b0, "oneshot_start");
        idle_steps(19, "oneshot_run");

        step(1'b1, 1'b0, 1'b1, "cont_start");
        idle_steps(40, "cont_run");
        step(1'b0, 1'b1, 1'b0, "cont_stop");
        idle_steps(3, "cont_after_stop");

        step(1'b1, 1'b0, 1'b0, "stop_start");
        idle_steps(5, "stop_run");
        step(1'b0, 1'b1, 1'b0, "stop_c6");
        idle_steps(20, "stop_after");

        step(1'b1, 1'b0, 1'b0, "restart_start");
        idle_steps(4, "restart_run");
        step(1'b1, 1'b0, 1'b1, "restart_repulse");
        idle_steps(20, "restart_after");

        step(1'b1, 1'b1, 1'b0, "start_stop_idle");
        idle_steps(3, "start_stop_after");

        step(1'b1, 1'b0, 1'b1, "midreset_start");
        idle_steps(9, "midreset_run");
        async_reset("midreset_async");
        step(1'b1, 1'b0, 1'b0, "midreset_held");
        step(1'b0, 1'b0, 1'b0, "midreset_held");
        rst_n = 1'b1;
        idle_steps(6, "midreset_release_idle");

        for (int k = 0; k < 400; k++) begin
            step(($urandom % 6) == 0, ($urandom % 25) == 0, $urandom % 2, "random");
        end
        idle_steps(20, "random_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
